// File: rtl/chirp_sweep_sequencer_if.sv
// Control/status bundle for chirp_sweep_sequencer.
// master: the controller side (config, start/stop, observes status).
// slave : the sequencer itself.
interface chirp_sweep_sequencer_if #(
  parameter int C_ADD_W = 14
);
  logic               cfg_we;
  logic [1:0]         cfg_addr;
  logic [15:0]        cfg_dat;
  logic               start;
  logic               stop;
  logic               busy;
  logic [C_ADD_W-1:0] add;
  logic               dir;
  logic               sweep_ee;
  logic               frame_done;
  logic               meas_gate;

  modport master (
    output cfg_we, cfg_addr, cfg_dat, start, stop,
    input  busy, add, dir, sweep_ee, frame_done, meas_gate
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_dat, start, stop,
    output busy, add, dir, sweep_ee, frame_done, meas_gate
  );
endinterface

// File: rtl/chirp_sweep_sequencer.sv
// FMCW chirp sequencer: drives the phase increment for the sine-table wave
// generator, sweeping between programmable MIN/MAX with a u4.12 STEP, a
// settle time at each end, and an optional frame count.
// Optional feature macro: SSWFMCW_SAW_EN (sawtooth sweep; default triangle).
module chirp_sweep_sequencer #(
  parameter int C_ADD_W   = 14,
  parameter int C_FRAC_W  = 12,
  parameter int C_MIN_RST = 13631,
  parameter int C_MAX_RST = 14331
) (
  input logic                    clk,
  input logic                    rst,
  chirp_sweep_sequencer_if.slave bus
);

  localparam int ACC_W  = C_ADD_W + C_FRAC_W;
  localparam int STEP_W = 16;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SET_UP = 3'd1;
  localparam logic [2:0] S_UP     = 3'd2;
  localparam logic [2:0] S_SET_DN = 3'd3;
  localparam logic [2:0] S_DOWN   = 3'd4;

  // configuration registers
  logic [C_ADD_W-1:0] min_r;
  logic [C_ADD_W-1:0] max_r;
  logic [STEP_W-1:0]  step_r;
  logic [7:0]         frames_r;
  logic [7:0]         settle_r;

  // sequencer state
  logic [2:0]       state, state_nx;
  logic [ACC_W-1:0] acc, acc_nx;
  logic [7:0]       settle_cnt, settle_nx;
  logic [7:0]       frame_ctr, frame_nx;
  logic             stop_pend, stop_nx;
  logic             sweep_ee_r, ee_nx;
  logic             frame_done_r, fd_nx;

  // derived arithmetic
  logic [STEP_W-1:0] step_eff;
  logic [ACC_W:0]    step_ext;
  logic [ACC_W-1:0]  min_fx;
  logic [ACC_W-1:0]  max_fx;
  logic [ACC_W:0]    up_sum;
  logic [ACC_W:0]    dn_lim;
  logic [ACC_W-1:0]  dn_dif;
  logic              up_hit;
  logic              dn_hit;
  logic              settle_done;
  logic [7:0]        frame_inc;
  logic              end_frame;
  logic              start_ok;

  // Arithmetic helpers. The down-limit test is done as acc <= MIN+STEP so
  // that the subtraction never has to wrap below zero.
  always_comb begin
    step_eff    = (step_r == '0) ? STEP_W'(1) : step_r;
    step_ext    = (ACC_W+1)'(step_eff);
    min_fx      = {min_r, {C_FRAC_W{1'b0}}};
    max_fx      = {max_r, {C_FRAC_W{1'b0}}};
    up_sum      = {1'b0, acc} + step_ext;
    dn_lim      = {1'b0, min_fx} + step_ext;
    dn_dif      = acc - step_ext[ACC_W-1:0];
    up_hit      = (up_sum >= {1'b0, max_fx});
    dn_hit      = ({1'b0, acc} <= dn_lim);
    settle_done = (settle_cnt == settle_r);
    frame_inc   = frame_ctr + 8'd1;
    end_frame   = stop_pend || ((frames_r != '0) && (frame_inc == frames_r));
    start_ok    = bus.start && (min_r < max_r);
  end

  // Config register writes, accepted only while idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      min_r    <= C_ADD_W'(C_MIN_RST);
      max_r    <= C_ADD_W'(C_MAX_RST);
      step_r   <= STEP_W'(1);
      frames_r <= '0;
      settle_r <= '0;
    end else if (bus.cfg_we && (state == S_IDLE)) begin
      case (bus.cfg_addr)
        2'd0: min_r <= bus.cfg_dat[C_ADD_W-1:0];
        2'd1: max_r <= bus.cfg_dat[C_ADD_W-1:0];
        2'd2: step_r <= bus.cfg_dat;
        default: begin
          frames_r <= bus.cfg_dat[15:8];
          settle_r <= bus.cfg_dat[7:0];
        end
      endcase
    end
  end

  // Next-state and accumulator update for the sweep FSM.
  always_comb begin
    state_nx  = state;
    acc_nx    = acc;
    settle_nx = settle_cnt;
    frame_nx  = frame_ctr;
    stop_nx   = stop_pend || (bus.stop && (state != S_IDLE));
    ee_nx     = 1'b0;
    fd_nx     = 1'b0;

    case (state)
      S_IDLE: begin
        stop_nx = 1'b0;
        acc_nx  = min_fx;
        if (start_ok) begin
          state_nx  = S_SET_UP;
          settle_nx = '0;
          frame_nx  = '0;
        end
      end

      S_SET_UP: begin
        acc_nx = min_fx;
        if (settle_done) begin
          state_nx  = S_UP;
          settle_nx = '0;
        end else begin
          settle_nx = settle_cnt + 8'd1;
        end
      end

      S_UP: begin
        if (up_hit) begin
          ee_nx     = 1'b1;
          settle_nx = '0;
`ifdef SSWFMCW_SAW_EN
          // Sawtooth: the turnaround is also the frame end.
          acc_nx   = min_fx;
          fd_nx    = 1'b1;
          frame_nx = frame_inc;
          if (end_frame) begin
            state_nx = S_IDLE;
            stop_nx  = 1'b0;
          end else begin
            state_nx = S_SET_UP;
          end
`else
          acc_nx   = max_fx;
          state_nx = S_SET_DN;
`endif
        end else begin
          acc_nx = up_sum[ACC_W-1:0];
        end
      end

`ifdef SSWFMCW_SAW_EN
      // No down-chirp states in sawtooth mode.
`else
      S_SET_DN: begin
        acc_nx = max_fx;
        if (settle_done) begin
          state_nx  = S_DOWN;
          settle_nx = '0;
        end else begin
          settle_nx = settle_cnt + 8'd1;
        end
      end

      S_DOWN: begin
        if (dn_hit) begin
          acc_nx    = min_fx;
          fd_nx     = 1'b1;
          frame_nx  = frame_inc;
          settle_nx = '0;
          if (end_frame) begin
            state_nx = S_IDLE;
            stop_nx  = 1'b0;
          end else begin
            state_nx = S_SET_UP;
          end
        end else begin
          acc_nx = dn_dif;
        end
      end
`endif

      default: begin
        state_nx = S_IDLE;
        acc_nx   = min_fx;
        stop_nx  = 1'b0;
      end
    endcase
  end

  // State registers; reset restores IDLE with acc at the reset MIN.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      acc          <= {C_ADD_W'(C_MIN_RST), {C_FRAC_W{1'b0}}};
      settle_cnt   <= '0;
      frame_ctr    <= '0;
      stop_pend    <= 1'b0;
      sweep_ee_r   <= 1'b0;
      frame_done_r <= 1'b0;
    end else begin
      state        <= state_nx;
      acc          <= acc_nx;
      settle_cnt   <= settle_nx;
      frame_ctr    <= frame_nx;
      stop_pend    <= stop_nx;
      sweep_ee_r   <= ee_nx;
      frame_done_r <= fd_nx;
    end
  end

  assign bus.add        = acc[ACC_W-1:C_FRAC_W];
  assign bus.busy       = (state != S_IDLE);
  assign bus.meas_gate  = (state == S_UP) || (state == S_DOWN);
`ifdef SSWFMCW_SAW_EN
  assign bus.dir        = 1'b0;
`else
  assign bus.dir        = (state == S_SET_DN) || (state == S_DOWN);
`endif
  assign bus.sweep_ee   = sweep_ee_r;
  assign bus.frame_done = frame_done_r;

endmodule
